l2_mem_write_buffer: RTL and testbench
======================================

Name: l2_mem_write_buffer

Overview:
- Line-granular write buffer between the L2 cache memory interface and main memory.
- Absorbs dirty-line writebacks so L2 does not wait on slow memory writes.
- Forwards buffered lines to L2 read misses and coalesces repeated writes to the same line.
- Drains entries to memory in FIFO order, with read misses taking priority over idle drains.

Parameters:
- DEPTH, 4, number of 128-bit line entries (power of two, 2..16).
- PTR_W, 2, log2(DEPTH), width of head/tail pointers.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- l2_read  in  1  L2 read request; held high until l2_ready.
- l2_write  in  1  L2 writeback request; held high until l2_ready.
- l2_addr  in  28  line address from L2.
- l2_wdata  in  128  line data for writeback.
- l2_rdata  out  128  line data returned to L2, valid while l2_ready=1.
- l2_ready  out  1  one-cycle completion pulse to L2.
- mem_read  out  1  memory read enable, held until mem_ready.
- mem_write  out  1  memory write enable, held until mem_ready.
- mem_addr  out  28  memory line address.
- mem_wdata  out  128  line data to memory.
- mem_rdata  in  128  line data from memory, valid with mem_ready.
- mem_ready  in  1  one-cycle memory completion; sampled on clk.
- wb_empty  out  1  high when no entries are buffered and no memory access is in flight.

Behaviour:
- Reset:
  - At a rising edge with reset=1, clear all entries, head, tail and count.
  - FSM goes to IDLE.
  - All outputs go to 0, except wb_empty=1.
  - An in-flight memory access is abandoned and buffered data is discarded.
- All outputs are registered.
- l2_read and l2_write are never both high; if they are, treat the request as a write.
- Request acceptance:
  - A request is sampled at an edge only when l2_ready=0 in the cycle preceding that edge.
  - Requests present in the cycle l2_ready=1 are ignored, which prevents double acceptance.
- Address match:
  - Compare l2_addr against all valid entries.
  - At most one entry can match, because of coalescing.
- Write, match on an entry not in flight: overwrite that entry's data in place. l2_ready pulses the next cycle.
- Write, no match, count<DEPTH: allocate at tail, tail++, count++. l2_ready pulses the next cycle.
- Write stalls (no l2_ready) when either:
  - count==DEPTH; or
  - the matching entry is the head currently being written to memory.
- A stalled write is retried every cycle. When the blocking head retires, the write allocates a fresh entry.
- Read hit (match):
  - l2_rdata = entry data, l2_ready pulses the next cycle. Zero memory traffic.
  - Hits on an in-flight head entry are allowed, since its data is stable.
- Read miss:
  - Latched as a pending read.
  - Issued to memory as soon as the FSM is IDLE.
  - If a drain is in flight, wait for its mem_ready; the read then beats the next drain.
- FSM states:
  - IDLE:
    - pending read -> RD_MEM, with mem_read=1, mem_addr=read addr.
    - else count>0 -> WR_MEM, with mem_write=1, mem_addr/mem_wdata=head entry.
  - RD_MEM: hold outputs. On sampled mem_ready -> RESP, with l2_rdata<=mem_rdata and mem_read=0.
  - RESP: l2_ready=1 for exactly one cycle -> IDLE.
  - WR_MEM: hold outputs. On sampled mem_ready: mem_write=0, head++, count-- -> IDLE.
- mem_read and mem_write are never high together.
- mem_read and mem_write drop the cycle after mem_ready is sampled.
- The earliest next memory request is issued one cycle after that.
- Simultaneous events in one edge:
  - A drain retire and a write allocate may occur together; count stays unchanged and both pointers advance.
  - A write when count==DEPTH that coincides with a retire still stalls that edge and is accepted the next edge.
- Pointers wrap modulo DEPTH.
- wb_empty = (count==0) && FSM==IDLE && no pending read.
- Latency:
  - Write accept or read hit: 1 cycle.
  - Read miss with idle buffer: mem_read asserts the cycle after acceptance; l2_ready follows 2 cycles after mem_ready.

Test Plan:
- Reset, then single write:
  - Stimulus: addr=0x0000010, data=0xA5..A5.
  - Response: l2_ready 1 cycle later.
  - Then mem_write with mem_addr=0x0000010 and mem_wdata=0xA5..A5 until mem_ready; wb_empty=1 afterwards.
- Coalescing:
  - Stimulus: hold mem_ready low; write 0x20 data=1, write 0x30 data=2, write 0x30 data=3.
  - Response: count=2. When drained, the memory sees 0x20 data=1 first, then 0x30 data=3 only.
- Full stall:
  - Stimulus: DEPTH=4, mem_ready low; five writes to distinct lines.
  - Response: the fifth write gets no l2_ready. After one mem_ready it is accepted on the following edge. Memory order 1,2,3,4,5.
- Read forwarding and miss priority:
  - Buffer 0x40 data=0xBEEF while the head is draining.
  - Read 0x40 -> l2_rdata=0xBEEF, no mem_read.
  - Read 0x50 -> mem_read issued after the current drain's mem_ready and before the next drain; l2_rdata=mem_rdata.
- Write to in-flight head:
  - Stimulus: write 0x60 while WR_MEM is draining 0x60.
  - Response: the write stalls until mem_ready, then allocates a new entry. 0x60 is written to memory twice, the second time with the new data.
- Reset mid-operation:
  - Stimulus: assert reset during WR_MEM with 3 entries buffered.
  - Response: next cycle mem_write=0, l2_ready=0, wb_empty=1. No further memory traffic.

Source files
------------

// File: rtl/l2_mem_write_buffer_if.sv
// L2-side request/response and memory-side handshake signals of the line write buffer.
// slave is the buffer's view; master is the view of the L2/memory environment around it.
interface l2_mem_write_buffer_if;
  logic         l2_read;
  logic         l2_write;
  logic [27:0]  l2_addr;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_ready;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         wb_empty;

  modport slave (
    input  l2_read, l2_write, l2_addr, l2_wdata, mem_rdata, mem_ready,
    output l2_rdata, l2_ready, mem_read, mem_write, mem_addr, mem_wdata, wb_empty
  );

  modport master (
    output l2_read, l2_write, l2_addr, l2_wdata, mem_rdata, mem_ready,
    input  l2_rdata, l2_ready, mem_read, mem_write, mem_addr, mem_wdata, wb_empty
  );
endinterface

// File: rtl/l2_mem_write_buffer.sv
// Coalescing line write buffer: write/read-hit complete in 1 cycle, read misses bypass drains.
// Writes stall (no l2_ready) when full or when hitting the head line currently being written out.
module l2_mem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  l2_mem_write_buffer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0] r_vld;
  logic [27:0]      r_addr [DEPTH];
  logic [127:0]     r_data [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic [1:0]       r_state;
  logic             r_pend;
  logic [27:0]      r_pend_addr;
  logic [127:0]     r_l2_rdata;
  logic             r_l2_ready;
  logic             r_mem_read;
  logic             r_mem_write;
  logic [27:0]      r_mem_addr;
  logic [127:0]     r_mem_wdata;
  logic             r_wb_empty;

  logic             w_hit;
  logic [PTR_W-1:0] w_hit_idx;
  logic             w_req_ok;
  logic             w_wr;
  logic             w_rd;
  logic             w_wr_blk;
  logic             w_wr_coal;
  logic             w_wr_alloc;
  logic             w_rd_hit;
  logic             w_rd_miss;
  logic             w_retire;
  logic [PTR_W:0]   w_count_nxt;
  logic [1:0]       w_state_nxt;
  logic             w_pend_nxt;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_addr[i] == bus.l2_addr)) begin
        w_hit     = 1'b1;
        w_hit_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    // The pending read keeps L2 blocked, so its still-held request is not re-sampled.
    w_req_ok   = !r_l2_ready && !r_pend;
    w_wr       = w_req_ok && bus.l2_write;
    w_rd       = w_req_ok && bus.l2_read && !bus.l2_write;
    w_wr_blk   = w_hit && (r_state == S_WR) && (w_hit_idx == r_head);
    w_wr_coal  = w_wr && w_hit && !w_wr_blk;
    w_wr_alloc = w_wr && !w_hit && (r_count != FULL_CNT);
    w_rd_hit   = w_rd && w_hit;
    w_rd_miss  = w_rd && !w_hit;
    w_retire   = (r_state == S_WR) && bus.mem_ready;

    w_count_nxt = r_count;
    if (w_wr_alloc && !w_retire) w_count_nxt = r_count + 1'b1;
    if (!w_wr_alloc && w_retire) w_count_nxt = r_count - 1'b1;

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_pend || w_rd_miss)  w_state_nxt = S_RD;
        else if (r_count != '0)   w_state_nxt = S_WR;
      end
      S_RD:    if (bus.mem_ready) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: if (bus.mem_ready) w_state_nxt = S_IDLE;
    endcase

    w_pend_nxt = (r_state == S_RESP) ? 1'b0 : (r_pend || w_rd_miss);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld       <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_state     <= S_IDLE;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_l2_rdata  <= '0;
      r_l2_ready  <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wb_empty  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_l2_ready <= 1'b0;
      r_count    <= w_count_nxt;
      r_state    <= w_state_nxt;
      r_pend     <= w_pend_nxt;
      r_wb_empty <= (w_count_nxt == '0) && (w_state_nxt == S_IDLE) && !w_pend_nxt;

      if (w_wr_coal) begin
        r_data[w_hit_idx] <= bus.l2_wdata;
        r_l2_ready        <= 1'b1;
      end
      if (w_wr_alloc) begin
        r_vld[r_tail]  <= 1'b1;
        r_addr[r_tail] <= bus.l2_addr;
        r_data[r_tail] <= bus.l2_wdata;
        r_tail         <= r_tail + 1'b1;
        r_l2_ready     <= 1'b1;
      end
      if (w_rd_hit) begin
        r_l2_rdata <= r_data[w_hit_idx];
        r_l2_ready <= 1'b1;
      end
      if (w_rd_miss) r_pend_addr <= bus.l2_addr;
      if (w_retire) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (r_pend || w_rd_miss) begin
            r_mem_read <= 1'b1;
            r_mem_addr <= r_pend ? r_pend_addr : bus.l2_addr;
          end else if (r_count != '0) begin
            r_mem_write <= 1'b1;
            r_mem_addr  <= r_addr[r_head];
            // A same-edge coalesce into the head must reach memory, not be lost on retire.
            r_mem_wdata <= (w_wr_coal && (w_hit_idx == r_head)) ? bus.l2_wdata : r_data[r_head];
          end
        end
        S_RD: begin
          if (bus.mem_ready) begin
            r_mem_read <= 1'b0;
            r_l2_rdata <= bus.mem_rdata;
          end
        end
        S_RESP:  r_l2_ready <= 1'b1;
        default: if (bus.mem_ready) r_mem_write <= 1'b0;
      endcase
    end
  end

  assign bus.l2_rdata  = r_l2_rdata;
  assign bus.l2_ready  = r_l2_ready;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.wb_empty  = r_wb_empty;

endmodule

// File: tb/tb_l2_mem_write_buffer.sv
// Directed bench for l2_mem_write_buffer: vector table on a stalled memory, then multi-cycle
// corner sequences (drain, miss priority, full stall, in-flight head write, mid-flight reset).
module tb_l2_mem_write_buffer;

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] data;
    int           exp_lat;
    logic [127:0] exp_rd;
  } vec_t;

  typedef struct {
    bit           is_rd;
    logic [27:0]  addr;
    logic [127:0] data;
  } mem_op_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  int      mem_auto = 0;
  int      mem_grants = 0;
  int      mem_delay = 0;
  int      mem_wait = 0;
  mem_op_t mlog[$];

  l2_mem_write_buffer_if bus();

  l2_mem_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rmodel(input logic [27:0] a);
    return {4{4'h5, a}};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input int idx, input bit is_rd, input logic [27:0] a, input logic [127:0] d);
    logic [159:0] got;
    got = '1;
    if (idx < mlog.size()) got = {3'b0, mlog[idx].is_rd, mlog[idx].addr, mlog[idx].data};
    chk($sformatf("memlog%0d", idx), got, {3'b0, is_rd, a, d});
  endtask

  task automatic do_req(input bit wr, input logic [27:0] a, input logic [127:0] d, input int maxc,
                        output int lat, output logic [127:0] rd);
    for (int i = 0; i < 4 && bus.l2_ready; i++) step();
    bus.l2_write = wr;
    bus.l2_read  = !wr;
    bus.l2_addr  = a;
    bus.l2_wdata = d;
    lat = 0;
    rd  = '0;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (bus.l2_ready) begin
        lat = i;
        rd  = bus.l2_rdata;
        break;
      end
    end
    bus.l2_write = 1'b0;
    bus.l2_read  = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 300 && !bus.wb_empty; i++) step();
    chk(name, 160'(bus.wb_empty), 160'(1));
  endtask

  task automatic do_reset();
    mem_auto   = 0;
    mem_grants = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    mlog.delete();
  endtask

  // Memory model: completes a held request after mem_delay cycles with a single-cycle mem_ready.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
      end else if ((bus.mem_read || bus.mem_write) && (mem_auto != 0 || mem_grants > 0)) begin
        if (mem_wait >= mem_delay) begin
          bus.mem_ready = 1'b1;
          mem_wait = 0;
          if (bus.mem_read) bus.mem_rdata = rmodel(bus.mem_addr);
          mlog.push_back('{bus.mem_read, bus.mem_addr, bus.mem_read ? rmodel(bus.mem_addr) : bus.mem_wdata});
          if (mem_auto == 0) mem_grants--;
        end else begin
          mem_wait++;
        end
      end else if (!(bus.mem_read || bus.mem_write)) begin
        mem_wait = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t         tv[12];
    int           lat;
    int           since;
    bit           prev_mw;
    bit           seen;
    logic [127:0] rd;
    logic [127:0] a5;

    tv[0]  = '{1'b1, 28'h20, 128'h1,     1, '0};
    tv[1]  = '{1'b1, 28'h30, 128'h2,     1, '0};
    tv[2]  = '{1'b1, 28'h30, 128'h3,     1, '0};
    tv[3]  = '{1'b0, 28'h20, '0,         1, 128'h1};
    tv[4]  = '{1'b0, 28'h30, '0,         1, 128'h3};
    tv[5]  = '{1'b1, 28'h40, 128'hBEEF,  1, '0};
    tv[6]  = '{1'b1, 28'h50, 128'h5,     1, '0};
    tv[7]  = '{1'b1, 28'h70, 128'h7,     0, '0};
    tv[8]  = '{1'b1, 28'h40, 128'h9,     1, '0};
    tv[9]  = '{1'b0, 28'h40, '0,         1, 128'h9};
    tv[10] = '{1'b1, 28'h20, 128'h11,    0, '0};
    tv[11] = '{1'b0, 28'h20, '0,         1, 128'h1};

    bus.l2_read = 1'b0;
    bus.l2_write = 1'b0;
    bus.l2_addr = '0;
    bus.l2_wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_l2_ready",  160'(bus.l2_ready),  '0);
    chk("rst_l2_rdata",  160'(bus.l2_rdata),  '0);
    chk("rst_mem_read",  160'(bus.mem_read),  '0);
    chk("rst_mem_write", 160'(bus.mem_write), '0);
    chk("rst_mem_addr",  160'(bus.mem_addr),  '0);
    chk("rst_mem_wdata", 160'(bus.mem_wdata), '0);
    chk("rst_wb_empty",  160'(bus.wb_empty),  160'(1));

    // Single write drains to memory.
    a5 = {16{8'hA5}};
    mem_delay = 2;
    mem_auto  = 1;
    do_req(1'b1, 28'h10, a5, 4, lat, rd);
    chk("single_wr_lat", 160'(lat), 160'(1));
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.mem_write) seen = 1'b1;
      else step();
    end
    chk("single_mem_write", 160'(seen), 160'(1));
    chk("single_mem_addr",  160'(bus.mem_addr),  160'(28'h10));
    chk("single_mem_wdata", 160'(bus.mem_wdata), 160'(a5));
    wait_empty("single_empty");
    chk("single_log_n", 160'(mlog.size()), 160'(1));
    chk_log(0, 1'b0, 28'h10, a5);

    // Read miss on an idle buffer.
    mem_delay = 0;
    mlog.delete();
    do_req(1'b0, 28'h90, '0, 10, lat, rd);
    chk("miss_lat",   160'(lat), 160'(3));
    chk("miss_rdata", 160'(rd),  160'(rmodel(28'h90)));
    chk_log(0, 1'b1, 28'h90, rmodel(28'h90));

    // Vector table against a stalled memory.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      do_req(tv[k].wr, tv[k].addr, tv[k].data, 4, lat, rd);
      chk($sformatf("vec%0d_lat", k), 160'(lat), 160'(tv[k].exp_lat));
      if (!tv[k].wr && tv[k].exp_lat != 0) chk($sformatf("vec%0d_rdata", k), 160'(rd), 160'(tv[k].exp_rd));
    end
    chk("tbl_mem_write", 160'(bus.mem_write), 160'(1));
    chk("tbl_mem_read",  160'(bus.mem_read),  '0);
    chk("tbl_mem_addr",  160'(bus.mem_addr),  160'(28'h20));
    chk("tbl_mem_wdata", 160'(bus.mem_wdata), 160'(1));
    chk("tbl_wb_empty",  160'(bus.wb_empty),  '0);
    mem_delay = 1;
    mem_auto  = 1;
    wait_empty("tbl_empty");
    chk("tbl_log_n", 160'(mlog.size()), 160'(4));
    chk_log(0, 1'b0, 28'h20, 128'h1);
    chk_log(1, 1'b0, 28'h30, 128'h3);
    chk_log(2, 1'b0, 28'h40, 128'h9);
    chk_log(3, 1'b0, 28'h50, 128'h5);

    // Full stall released by one retire.
    do_reset();
    mem_delay = 0;
    for (int k = 0; k < 4; k++) begin
      do_req(1'b1, 28'h100 + 28'(k), 128'(k + 1), 4, lat, rd);
      chk($sformatf("full_wr%0d_lat", k), 160'(lat), 160'(1));
    end
    do_req(1'b1, 28'h104, 128'h5, 3, lat, rd);
    chk("full_stall_lat", 160'(lat), '0);
    bus.l2_write = 1'b1;
    bus.l2_addr  = 28'h104;
    bus.l2_wdata = 128'h5;
    mem_grants = 1;
    prev_mw = bus.mem_write;
    since = -1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (since >= 0) since++;
      if (since < 0 && prev_mw && !bus.mem_write) since = 0;
      prev_mw = bus.mem_write;
      if (bus.l2_ready) seen = 1'b1;
    end
    bus.l2_write = 1'b0;
    chk("full_release_seen", 160'(seen), 160'(1));
    chk("full_release_delay", 160'(since), 160'(1));
    mem_auto = 1;
    wait_empty("full_empty");
    chk("full_log_n", 160'(mlog.size()), 160'(5));
    for (int k = 0; k < 5; k++) chk_log(k, 1'b0, 28'h100 + 28'(k), 128'(k + 1));

    // Read forwarding and miss priority over the next drain.
    do_reset();
    do_req(1'b1, 28'h40, 128'hBEEF, 4, lat, rd);
    do_req(1'b1, 28'h44, 128'h44, 4, lat, rd);
    do_req(1'b0, 28'h40, '0, 4, lat, rd);
    chk("fwd_lat",      160'(lat), 160'(1));
    chk("fwd_rdata",    160'(rd),  160'(128'hBEEF));
    chk("fwd_mem_read", 160'(bus.mem_read), '0);
    mem_delay = 1;
    mem_auto  = 1;
    do_req(1'b0, 28'h50, '0, 30, lat, rd);
    chk("prio_seen",  160'(lat != 0), 160'(1));
    chk("prio_rdata", 160'(rd), 160'(rmodel(28'h50)));
    wait_empty("prio_empty");
    chk("prio_log_n", 160'(mlog.size()), 160'(3));
    chk_log(0, 1'b0, 28'h40, 128'hBEEF);
    chk_log(1, 1'b1, 28'h50, rmodel(28'h50));
    chk_log(2, 1'b0, 28'h44, 128'h44);

    // Write to the head line while it is being written out.
    do_reset();
    mem_delay = 0;
    do_req(1'b1, 28'h60, 128'h600, 4, lat, rd);
    step();
    do_req(1'b1, 28'h60, 128'h601, 3, lat, rd);
    chk("head_stall_lat", 160'(lat), '0);
    bus.l2_write = 1'b1;
    bus.l2_addr  = 28'h60;
    bus.l2_wdata = 128'h601;
    mem_grants = 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (bus.l2_ready) seen = 1'b1;
    end
    bus.l2_write = 1'b0;
    chk("head_release_seen", 160'(seen), 160'(1));
    mem_auto = 1;
    wait_empty("head_empty");
    chk("head_log_n", 160'(mlog.size()), 160'(2));
    chk_log(0, 1'b0, 28'h60, 128'h600);
    chk_log(1, 1'b0, 28'h60, 128'h601);

    // Reset while a drain is in flight.
    do_reset();
    for (int k = 0; k < 3; k++) do_req(1'b1, 28'h200 + 28'(k), 128'(k + 8), 4, lat, rd);
    step();
    chk("mid_pre_mem_write", 160'(bus.mem_write), 160'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_mem_write", 160'(bus.mem_write), '0);
    chk("mid_l2_ready",  160'(bus.l2_ready),  '0);
    chk("mid_wb_empty",  160'(bus.wb_empty),  160'(1));
    mlog.delete();
    mem_auto = 1;
    repeat (10) step();
    chk("mid_no_traffic", 160'(mlog.size()), '0);
    chk("mid_still_empty", 160'(bus.wb_empty), 160'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
